// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: ALU function
// codes, counter/data widths and the FSM state encoding.
package mul_seq_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ALU_FUNC_W = 6;
  localparam int unsigned CNT_W      = 6;

  // Function codes understood by the external shared ALU
  localparam logic [ALU_FUNC_W-1:0] ALU_SLL = 6'h04;
  localparam logic [ALU_FUNC_W-1:0] ALU_SRL = 6'h06;
  localparam logic [ALU_FUNC_W-1:0] ALU_SRA = 6'h07;
  localparam logic [ALU_FUNC_W-1:0] ALU_NOP = 6'h15;
  localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 6'h20;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 6'h22;
  localparam logic [ALU_FUNC_W-1:0] ALU_AND = 6'h24;
  localparam logic [ALU_FUNC_W-1:0] ALU_OR  = 6'h25;
  localparam logic [ALU_FUNC_W-1:0] ALU_XOR = 6'h26;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier borrowing an external ALU for the adds.
// Define MUL_SEQ_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned ITERS  = 32,
  parameter int unsigned FUNC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  output logic              busy,
  output logic              done,
  output logic [31:0]       product,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [31:0]       alu_result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_e             state;
  logic [DATA_W-1:0]  mcand;
  logic [DATA_W-1:0]  mplier;
  logic [DATA_W-1:0]  acc;
  logic [CNT_W-1:0]   cnt;
  logic               last_c;

  // Final RUN cycle detection
`ifdef MUL_SEQ_EARLY_TERM_EN
  assign last_c = (cnt == LAST_CNT) || ((mplier >> 1) == '0);
`else
  assign last_c = (cnt == LAST_CNT);
`endif

  // ALU request must track the current acc/mplier, so it is decoded from state
  always_comb begin
    alu_func = FUNC_W'(ALU_NOP);
    alu_a    = '0;
    alu_b    = '0;
    if (state == ST_RUN) begin
      alu_func = FUNC_W'(ALU_ADD);
      alu_a    = acc;
      alu_b    = mplier[0] ? mcand : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_c) begin
            product <= alu_result;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter ITERS, default 32, meaning the number of multiplier bits processed in a full run.
REQ-002 SHALL have parameter FUNC_W, default 6, meaning the width of the shared-ALU function code.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a multiply.
REQ-006 SHALL have port op_a, input, 32, the multiplicand.
REQ-007 SHALL have port op_b, input, 32, the multiplier.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-010 SHALL have port product, output, 32, the low 32 bits of op_a*op_b; valid from done until the next accepted start.
REQ-011 SHALL have port alu_a, output, 32, operand A to the shared ALU.
REQ-012 SHALL have port alu_b, output, 32, operand B to the shared ALU.
REQ-013 SHALL have port alu_func, output, FUNC_W, the function code to the shared ALU.
REQ-014 SHALL have port alu_result, input, 32, the combinational result from the shared ALU.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE: start=1 SHALL latch mcand=op_a, mplier=op_b, acc=0, cnt=0, and move to RUN; busy SHALL rise the next cycle.
REQ-017 RUN: each cycle SHALL drive alu_func=6'h20 (ADD), alu_a=acc, and alu_b=mcand if mplier[0] else 32'h0.
REQ-018 RUN: each cycle SHALL also set acc<=alu_result, mcand<=mcand<<1 (internal, zero fill), mplier<=mplier>>1 (logical), cnt<=cnt+1.
REQ-019 RUN SHALL go to DONE after the cycle in which cnt==ITERS-1; a full run is exactly ITERS RUN cycles.
REQ-020 DONE SHALL last one cycle with done=1, busy=0, product=acc, then return to IDLE.
REQ-021 Latency: start sampled at edge 0 -> done high in cycle ITERS+1 (33 by default).
REQ-022 IDLE and DONE SHALL drive alu_func=6'h15 (NOP), alu_a=0, alu_b=0.
REQ-023 start while busy (RUN) or in DONE SHALL be ignored, with no effect on the in-flight operation.
REQ-024 product SHALL hold its value through IDLE and change only on entry to DONE.
REQ-025 Arithmetic SHALL be modulo 2^32; a carry out of the ADD is discarded, and the result is identical for signed and unsigned operands.
REQ-026 cnt SHALL be 6 bits wide and SHALL never wrap during a run.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, busy=0, done=0, product=0, acc=0, mcand=0, mplier=0, cnt=0, and the ALU outputs to their NOP values.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and the first start after release SHALL begin a fresh run.

Configuration
REQ-029 Macro MUL_SEQ_EARLY_TERM_EN defined: RUN SHALL go to DONE after any cycle in which the next mplier value (mplier>>1) is zero, or cnt==ITERS-1, whichever comes first.
REQ-030 With MUL_SEQ_EARLY_TERM_EN, op_b==0 SHALL still consume one RUN cycle, so done arrives in cycle 2.
REQ-031 Macro MUL_SEQ_EARLY_TERM_EN undefined: latency SHALL be fixed at ITERS+1 regardless of operands.

Structure
REQ-032 A shared package SHALL hold the ALU function constants (SLL 6'h04, SRL 6'h06, SRA 6'h07, NOP 6'h15, ADD 6'h20, SUB 6'h22, and the rest) and the FSM state encoding.
REQ-033 No sub-module; the ALU is external and connected through the alu_* ports.

Verification
REQ-034 op_a=3, op_b=5, start pulse -> done in cycle 33, product=32'd15, and alu_func=6'h20 on every busy cycle.
REQ-035 op_a=op_b=32'hFFFFFFFF -> product=32'h00000001; op_a=op_b=32'h00010000 -> product=32'h0.
REQ-036 With MUL_SEQ_EARLY_TERM_EN: op_a=7, op_b=1 -> done in cycle 2, product=7; op_b=32'h80000000 -> done in cycle 33.
REQ-037 Start op_a=2, op_b=9, then start op_a=4, op_b=4 in cycle 10 -> product=18 in cycle 33, with the second start ignored.
REQ-038 rst_n low in cycle 12 of a run -> all outputs zero and no done; a new start op_a=6, op_b=7 -> product=42.
